relm_custom_muldiv: RTL and testbench
=====================================

Name: relm_custom_muldiv

Overview:
- Multi-cycle custom-instruction unit for the ReLM core; parametrised successor to the combinational custom slot.
- Executes unsigned/signed multiply and unsigned divide with a radix-2 iterative datapath.
- Uses a request/busy/done handshake so the core stalls while the unit is busy.
- Keeps the custom-slot operand set (a, cb, x, xb, opb) and the extended cb channel of width WC+WD.

Parameters:
WD, 32, data word width; legal range 8..64.
WOP, 5, width of op_in.
WC, 32, extra cb width; must be 0 or WD. Upper WC bits of cb are a tag passthrough.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_in  input  1  start pulse; sampled only in IDLE.
op_in  input  WOP  op_in[1:0] selects the sub-op; upper bits ignored.
a_in  input  WD  operand A (dividend / multiplicand).
cb_in  input  WC+WD  cb_in[WC+WD-1:WD] is the tag, latched at request; low WD bits are ignored.
x_in  input  WD  operand B candidate 0.
xb_in  input  WD  operand B candidate 1.
opb_in  input  1  selects B: 0 selects x_in, 1 selects xb_in.
busy_out  output  1  high while an operation is in progress.
done_out  output  1  one-cycle pulse; results are valid from this cycle.
a_out  output  WD  primary result.
cb_out  output  WC+WD  {tag, secondary result}.

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE; busy_out, done_out, a_out, cb_out and all internal registers clear to 0.
- Sub-ops (op_in[1:0]):
  - 00 MULU: {hi, lo} = A*B unsigned. a_out = lo, cb_out[WD-1:0] = hi.
  - 01 MULS: same as MULU with two's-complement operands. Magnitudes are multiplied and the 2WD-bit product is negated when sign(A) xor sign(B) is 1.
  - 10 DIVU: a_out = A/B, cb_out[WD-1:0] = A%B. Divide by zero gives a_out = all ones and remainder = A.
  - 11: reserved. a_out = 0, cb_out[WD-1:0] = 0.
- States:
  - IDLE: on req_in, latch A, B (selected via opb_in), op and tag. Go to RUN with step counter = 0. For op 11, go directly to DONE.
  - RUN: one shift-add (mul) or shift-subtract-restore (div) step per cycle. Counter counts 0..WD-1; after step WD-1, go to DONE.
  - DONE: load a_out and cb_out, apply sign correction, assert done_out for one cycle, return to IDLE.
- busy_out = 1 in RUN and DONE, 0 in IDLE. done_out is registered and asserts in the cycle after DONE is entered.
- Latency: with req_in sampled at edge 0, done_out is high in the cycle after edge WD+1 (ops 00..10) or after edge 1 (op 11).
- a_out and cb_out hold their last values until the next done_out; they do not change on req_in.
- req_in while busy_out = 1 is ignored. Operands are not re-latched and no queueing takes place.
- req_in in the same cycle that done_out pulses is accepted, since the state is IDLE at that edge.
- cb_out[WC+WD-1:WD] = tag latched at request; the field is absent when WC = 0.
- Operand inputs may change freely after the request edge; the result depends only on latched values.
- rst_n asserted mid-operation aborts it: no done_out pulse and outputs return to 0.
- Arithmetic: internal accumulator is 2WD bits; the divider partial remainder is WD+1 bits. No overflow flag. MULS of min*min yields the correct 2WD-bit product.

Test Plan (WD=32, WC=32):
- MULU 0xFFFFFFFF * 0x2, req at edge 0 -> done_out after edge 33, a_out = 0xFFFFFFFE, cb_out[31:0] = 0x1.
- MULS -3 * 7 with opb_in=1 (xb_in=7, x_in=0x55) -> a_out = 0xFFFFFFEB, cb_out[31:0] = 0xFFFFFFFF.
- DIVU 100/7 with cb_in tag 0xCAFEBABE -> a_out = 14, cb_out = {0xCAFEBABE, 0x2}.
- DIVU 0x1234/0 -> a_out = 0xFFFFFFFF, cb_out[31:0] = 0x1234.
- Second req_in at edge 5 of a MULU -> ignored: exactly one done_out pulse, result of the first request only.
- rst_n low at edge 10 of a DIVU -> busy_out 0 immediately, outputs 0, no done_out. Then op 11 request -> done_out after edge 1 with a_out = 0.

Source files
------------

// File: rtl/relm_custom_muldiv.sv
// relm_custom_muldiv: multi-cycle radix-2 multiply/divide custom-instruction unit
//   clk, rst_n            clock, asynchronous active-low reset
//   req_in, op_in         start pulse (sampled in IDLE), op_in[1:0] = MULU/MULS/DIVU/reserved
//   a_in, x_in, xb_in     operand A and the two operand B candidates
//   opb_in                B select (0: x_in, 1: xb_in)
//   cb_in                 upper WC bits are a tag passed through to cb_out
//   busy_out, done_out    busy in RUN/DONE, one-cycle done pulse
//   a_out, cb_out         primary result, {tag, secondary result}
module relm_custom_muldiv #(
    parameter int WD  = 32,
    parameter int WOP = 5,
    parameter int WC  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_in,
    input  logic [WOP-1:0]    op_in,
    input  logic [WD-1:0]     a_in,
    input  logic [WC+WD-1:0]  cb_in,
    input  logic [WD-1:0]     x_in,
    input  logic [WD-1:0]     xb_in,
    input  logic              opb_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [WD-1:0]     a_out,
    output logic [WC+WD-1:0]  cb_out
);
    localparam int CW = $clog2(WD);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*WD-1:0]   acc_q, acc_d;
    logic [WD-1:0]     rem_q, rem_d;
    logic [WD-1:0]     b_q, b_d;
    logic              neg_q, neg_d;
    logic [WC+WD-1:0]  tag_q, tag_d;
    logic [WD-1:0]     a_out_q, a_out_d;
    logic [WC+WD-1:0]  cb_out_q, cb_out_d;
    logic              done_q, done_d;
    logic [WD-1:0]     b_sel, a_mag, b_mag, div_diff;
    logic [WD:0]       mul_sum, div_sh;
    logic [2*WD-1:0]   prod;
    logic              muls, div_ge;
    logic              unused_op;
    assign unused_op = ^op_in;
    assign busy_out  = state_q != IDLE;
    assign done_out  = done_q;
    assign a_out     = a_out_q;
    assign cb_out    = cb_out_q;
    always_comb begin
        b_sel    = opb_in ? xb_in : x_in;
        muls     = op_in[1:0] == 2'b01;
        a_mag    = (muls && a_in[WD-1]) ? -a_in : a_in;
        b_mag    = (muls && b_sel[WD-1]) ? -b_sel : b_sel;
        // acc = {partial product high, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[2*WD-1:WD]} + {1'b0, acc_q[0] ? b_q : '0};
        // restoring division: dividend bits shift out of acc[WD-1:0], quotient bits shift in
        div_sh   = {rem_q, acc_q[WD-1]};
        div_ge   = div_sh >= {1'b0, b_q};
        div_diff = div_sh[WD-1:0] - b_q;
        prod     = neg_q ? -acc_q : acc_q;
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        b_d      = b_q;
        neg_d    = neg_q;
        tag_d    = tag_q;
        a_out_d  = a_out_q;
        cb_out_d = cb_out_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (req_in) begin
                op_d    = op_in[1:0];
                tag_d   = cb_in;
                neg_d   = muls && (a_in[WD-1] ^ b_sel[WD-1]);
                b_d     = b_mag;
                acc_d   = {{WD{1'b0}}, a_mag};
                rem_d   = '0;
                cnt_d   = '0;
                state_d = (op_in[1:0] == 2'b11) ? DONE : RUN;
            end
            RUN: begin
                if (op_q[1]) begin
                    rem_d = div_ge ? div_diff : div_sh[WD-1:0];
                    acc_d = {acc_q[2*WD-1:WD], acc_q[WD-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WD-1:1]};
                end
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WD-1)) ? DONE : RUN;
            end
            DONE: begin
                a_out_d  = (op_q == 2'b11) ? '0 : op_q[1] ? acc_q[WD-1:0] : prod[WD-1:0];
                cb_out_d = tag_q;
                cb_out_d[WD-1:0] = (op_q == 2'b11) ? '0 : op_q[1] ? rem_q : prod[2*WD-1:WD];
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            tag_q    <= '0;
            a_out_q  <= '0;
            cb_out_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            tag_q    <= tag_d;
            a_out_q  <= a_out_d;
            cb_out_q <= cb_out_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_relm_custom_muldiv.sv
// tb_relm_custom_muldiv: scoreboard bench for relm_custom_muldiv
module tb_relm_custom_muldiv;
    localparam int WD = 32, WOP = 5, WC = 32;
    logic              clk = 1'b0, rst_n = 1'b0, req_in = 1'b0, opb_in = 1'b0;
    logic [WOP-1:0]    op_in = '0;
    logic [WD-1:0]     a_in = '0, x_in = '0, xb_in = '0;
    logic [WC+WD-1:0]  cb_in = '0;
    logic              busy_out, done_out;
    logic [WD-1:0]     a_out;
    logic [WC+WD-1:0]  cb_out;
    typedef struct {logic [31:0] a; logic [63:0] cb;} exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0, done_cnt = 0, d0 = 0;
    relm_custom_muldiv #(.WD(WD), .WOP(WOP), .WC(WC)) dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .op_in(op_in), .a_in(a_in),
        .cb_in(cb_in), .x_in(x_in), .xb_in(xb_in), .opb_in(opb_in),
        .busy_out(busy_out), .done_out(done_out), .a_out(a_out), .cb_out(cb_out)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done_out) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done act=1 exp=0");
            end else begin
                e = sb.pop_front();
                chk("a_out", {32'h0, a_out}, {32'h0, e.a});
                chk("cb_out", cb_out, e.cb);
            end
        end
    end
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] x,
                         input logic [31:0] xb, input logic ob, input logic [31:0] tag,
                         input logic [31:0] ea, input logic [31:0] ehi);
        exp_t e;
        op_in  = {3'b101, op};
        a_in   = a;
        x_in   = x;
        xb_in  = xb;
        opb_in = ob;
        cb_in  = {tag, 32'h5A5A0F0F};
        req_in = 1'b1;
        e.a  = ea;
        e.cb = {tag, ehi};
        sb.push_back(e);
        @(negedge clk);
        req_in = 1'b0;
        a_in   = $urandom;
        x_in   = $urandom;
        xb_in  = $urandom;
        opb_in = ~ob;
        cb_in  = {$urandom, $urandom};
    endtask
    task automatic wait_done(input int exp_n, input string name);
        int n = 0;
        while (!done_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n), 64'(exp_n));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'h0, busy_out}, 64'h0);
        chk("rst_done", {63'h0, done_out}, 64'h0);
        chk("rst_a", {32'h0, a_out}, 64'h0);
        chk("rst_cb", cb_out, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'hFFFFFFFF, 32'h2, 32'h0, 1'b0, 32'h11111111, 32'hFFFFFFFE, 32'h1);
        chk("busy_run", {63'h0, busy_out}, 64'h1);
        wait_done(WD + 1, "lat_mulu");
        @(negedge clk);
        chk("done_pulse", {63'h0, done_out}, 64'h0);
        chk("busy_idle", {63'h0, busy_out}, 64'h0);
        issue(2'b01, 32'hFFFFFFFD, 32'h55, 32'h7, 1'b1, 32'h0, 32'hFFFFFFEB, 32'hFFFFFFFF);
        chk("hold_on_req", {32'h0, a_out}, 64'hFFFFFFFE);
        wait_done(WD + 1, "lat_muls");
        issue(2'b10, 32'd100, 32'd7, 32'h0, 1'b0, 32'hCAFEBABE, 32'd14, 32'd2);
        wait_done(WD + 1, "lat_b2b");
        issue(2'b10, 32'h1234, 32'h0, 32'h99, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h1234);
        wait_done(WD + 1, "lat_div0");
        issue(2'b01, 32'h80000000, 32'h80000000, 32'h0, 1'b0, 32'h0, 32'h0, 32'h40000000);
        wait_done(WD + 1, "lat_minmin");
        issue(2'b01, 32'd5, 32'hFFFFFFFC, 32'h0, 1'b0, 32'h3, 32'hFFFFFFEC, 32'hFFFFFFFF);
        wait_done(WD + 1, "lat_muls2");
        issue(2'b10, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0);
        wait_done(WD + 1, "lat_div1");
        issue(2'b10, 32'd7, 32'h0, 32'd100, 1'b1, 32'h0, 32'h0, 32'd7);
        wait_done(WD + 1, "lat_divsmall");
        @(negedge clk);
        d0 = done_cnt;
        issue(2'b00, 32'd3, 32'd4, 32'h0, 1'b0, 32'h77, 32'd12, 32'd0);
        repeat (4) @(negedge clk);
        op_in  = '0;
        a_in   = 32'd9;
        x_in   = 32'd9;
        opb_in = 1'b0;
        req_in = 1'b1;
        @(negedge clk);
        req_in = 1'b0;
        wait_done(WD - 4, "lat_ignored");
        repeat (40) @(negedge clk);
        chk("one_done", 64'(done_cnt - d0), 64'd1);
        issue(2'b10, 32'd1000, 32'd3, 32'h0, 1'b0, 32'h1, 32'd333, 32'd1);
        repeat (9) @(negedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        sb.delete();
        d0 = done_cnt;
        #1;
        chk("abort_busy", {63'h0, busy_out}, 64'h0);
        chk("abort_done", {63'h0, done_out}, 64'h0);
        chk("abort_a", {32'h0, a_out}, 64'h0);
        chk("abort_cb", cb_out, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        issue(2'b11, 32'd5, 32'd6, 32'd7, 1'b0, 32'hA5A5A5A5, 32'h0, 32'h0);
        wait_done(1, "lat_rsvd");
        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
